// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone read/write arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        ABORT = 2'd3
    } owner_state_t;

    typedef enum logic {
        MASTER_A = 1'b0,
        MASTER_B = 1'b1
    } master_t;

    // B counts as the previous owner after reset so A wins the first tie.
    localparam master_t OWNER_RESET = MASTER_B;

endpackage

// File: rtl/wb_arb_ack_watchdog.sv
// Outstanding-request counter plus ack watchdog for the current bus owner.
module wb_ack_watchdog #(
    parameter int LGDEPTH = 4,
    parameter int TIMEOUT = 0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_req,
    input  logic i_ack,
    input  logic i_err,
    input  logic i_clear,
    output logic o_saturated,
    output logic o_timeout
);

    localparam logic [LGDEPTH-1:0] COUNT_MAX = '1;

    logic [LGDEPTH-1:0] count_q, count_d;

    assign o_saturated = (count_q == COUNT_MAX);

    // Outstanding count: clears on err/clear, never wraps or underflows.
    always_comb begin
        count_d = count_q;
        if (i_clear || i_err) begin
            count_d = '0;
        end else if (i_req && !i_ack) begin
            if (!o_saturated) count_d = count_q + 1'b1;
        end else if (i_ack && !i_req) begin
            if (count_q != '0) count_d = count_q - 1'b1;
        end
    end

    // Outstanding count register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) count_q <= '0;
        else         count_q <= count_d;
    end

    if (TIMEOUT > 0) begin : g_watchdog
        localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
        localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

        logic [TW-1:0] timer_q, timer_d;
        logic          waiting;

        assign waiting   = !i_clear && !i_ack && !i_err && (count_q != '0);
        assign o_timeout = waiting && (timer_q == TLIM);

        // Timer counts ack-less cycles while requests are outstanding.
        always_comb begin
            timer_d = timer_q;
            if (!waiting)             timer_d = '0;
            else if (timer_q != TLIM) timer_d = timer_q + 1'b1;
        end

        // Watchdog timer register.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) timer_q <= '0;
            else         timer_q <= timer_d;
        end
    end else begin : g_no_watchdog
        assign o_timeout = 1'b0;
    end

endmodule

// File: rtl/wb_rdwr_arbiter.sv
// Two-master round-robin Wishbone B4 pipelined arbiter with ack watchdog.
module wb_rdwr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int LGDEPTH = 4,
    parameter int TIMEOUT = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    owner_state_t state_q, state_d;
    master_t      last_owner_q, last_owner_d;

    logic own_a, own_b;
    logic owner_cyc, owner_stb;
    logic bus_stb, bus_ack, bus_err;
    logic wd_saturated, wd_timeout, wd_fire;

    assign own_a     = (state_q == OWN_A);
    assign own_b     = (state_q == OWN_B);
    assign owner_cyc = (own_a && i_a_cyc) || (own_b && i_b_cyc);
    assign owner_stb = (own_a && i_a_stb) || (own_b && i_b_stb);
    // Strobe is withheld at saturation so the slave never sees a request
    // the owner was told is stalled.
    assign bus_stb   = owner_cyc && owner_stb && !wd_saturated;
    assign bus_ack   = i_wb_ack && owner_cyc;
    assign bus_err   = i_wb_err && owner_cyc;
    assign wd_fire   = wd_timeout && owner_cyc;

    assign o_a_data  = i_wb_data;
    assign o_b_data  = i_wb_data;

    wb_ack_watchdog #(
        .LGDEPTH (LGDEPTH),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       (bus_stb && !i_wb_stall),
        .i_ack       (bus_ack),
        .i_err       (bus_err),
        .i_clear     (!owner_cyc),
        .o_saturated (wd_saturated),
        .o_timeout   (wd_timeout)
    );

    // Route the owner's request to the slave and the slave's response back.
    always_comb begin
        o_wb_cyc  = owner_cyc;
        o_wb_stb  = bus_stb;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_wb_sel  = '0;
        o_a_stall = 1'b1;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_b_stall = 1'b1;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;
        if (own_a) begin
            o_wb_we   = i_a_we;
            o_wb_addr = i_a_addr;
            o_wb_data = i_a_data;
            o_wb_sel  = i_a_sel;
            o_a_stall = i_wb_stall || wd_saturated;
            o_a_ack   = bus_ack;
            o_a_err   = bus_err || wd_fire;
        end else if (own_b) begin
            o_wb_we   = i_b_we;
            o_wb_addr = i_b_addr;
            o_wb_data = i_b_data;
            o_wb_sel  = i_b_sel;
            o_b_stall = i_wb_stall || wd_saturated;
            o_b_ack   = bus_ack;
            o_b_err   = bus_err || wd_fire;
        end
    end

    // Ownership next-state: round-robin grant, release handoff, abort.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (i_a_cyc && i_b_cyc) begin
                    if (last_owner_q == MASTER_B) begin
                        state_d      = OWN_A;
                        last_owner_d = MASTER_A;
                    end else begin
                        state_d      = OWN_B;
                        last_owner_d = MASTER_B;
                    end
                end else if (i_a_cyc) begin
                    state_d      = OWN_A;
                    last_owner_d = MASTER_A;
                end else if (i_b_cyc) begin
                    state_d      = OWN_B;
                    last_owner_d = MASTER_B;
                end
            end
            OWN_A: begin
                if (!i_a_cyc) begin
                    if (i_b_cyc) begin
                        state_d      = OWN_B;
                        last_owner_d = MASTER_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wd_fire) begin
                    state_d = ABORT;
                end
            end
            OWN_B: begin
                if (!i_b_cyc) begin
                    if (i_a_cyc) begin
                        state_d      = OWN_A;
                        last_owner_d = MASTER_A;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wd_fire) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if ((last_owner_q == MASTER_A) ? !i_a_cyc : !i_b_cyc)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Owner state and round-robin history registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_RESET;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule
